// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M multiply/divide controller for the EX stage.
// Shift-add multiply and restoring divide, one bit per cycle, stalling the pipeline while busy.
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     op_q, op_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [2:0]           f3_q, f3_d;
  logic                 neg_q, neg_d;

  logic                 sgn_a, sgn_b, neg_a, neg_b, is_mul, div_zero, div_ovf;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       mul_sum, div_shift, div_diff;
  logic                 div_ok;
  logic [2*WIDTH-1:0]   mul_next, div_next, prod;
  logic [WIDTH-1:0]     mul_res, div_mag, div_res;

  // Operand decode: which sources are signed for this funct3.
  always_comb begin
    sgn_a    = (funct3[2] & ~funct3[0]) | (~funct3[2] & (funct3[1] ^ funct3[0]));
    sgn_b    = (funct3 == 3'd1) | (funct3[2] & ~funct3[0]);
    neg_a    = sgn_a & src_a[WIDTH-1];
    neg_b    = sgn_b & src_b[WIDTH-1];
    mag_a    = neg_a ? -src_a : src_a;
    mag_b    = neg_b ? -src_b : src_b;
    is_mul   = ~funct3[2];
    div_zero = (src_b == '0);
    div_ovf  = ~funct3[0] & (src_a == {1'b1, {(WIDTH-1){1'b0}}}) & (&src_b);
  end

  // Datapath steps: acc holds {hi, lo}; multiply shifts right, divide shifts left.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, op_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, op_q};
    div_ok    = ~div_diff[WIDTH];
    div_next  = {(div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                 acc_q[WIDTH-2:0], div_ok};
    prod      = neg_q ? -mul_next : mul_next;
    mul_res   = (f3_q == 3'd0) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
    div_mag   = f3_q[1] ? div_next[2*WIDTH-1:WIDTH] : div_next[WIDTH-1:0];
    div_res   = neg_q ? -div_mag : div_mag;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    op_d     = op_q;
    f3_d     = f3_q;
    neg_d    = neg_q;
    result_d = result_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          f3_d  = funct3;
          cnt_d = '0;
          op_d  = is_mul ? mag_a : mag_b;
          acc_d = {{WIDTH{1'b0}}, (is_mul ? mag_b : mag_a)};
          if (is_mul) begin
            neg_d   = neg_a ^ neg_b;
            state_d = StMul;
          end else begin
            neg_d = funct3[1] ? neg_a : (neg_a ^ neg_b);
            if (div_zero) begin
              result_d = funct3[1] ? src_a : '1;
              state_d  = StDone;
            end else if (div_ovf) begin
              result_d = funct3[1] ? '0 : src_a;
              state_d  = StDone;
            end else begin
              state_d = StDiv;
            end
          end
        end
      end
      StMul: begin
        acc_d = mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          result_d = mul_res;
          state_d  = StDone;
        end
      end
      StDiv: begin
        acc_d = div_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          result_d = div_res;
          state_d  = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
    // Abort wins over everything but reset; result keeps its last completed value.
    if (flush) begin
      state_d  = StIdle;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      op_q     <= '0;
      f3_q     <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      op_q     <= op_d;
      f3_q     <= f3_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == StMul) || (state_q == StDiv);
  assign done   = (state_q == StDone);
  assign result = result_q;
  assign stall  = ((state_q == StIdle) & start & ~flush) | busy;

endmodule
